// File: rtl/reg_write_scheduler.sv
// reg_write_scheduler
//   Sole owner of the register-file write port. Four writeback sources
//   (0 ALU, 1 load, 2 immediate/move, 3 multi-cycle unit) are arbitrated
//   round-robin. The winner's register index, data and source select are
//   registered one cycle later and drive the register-file write port and the
//   register C mux. A busy scoreboard tracks destinations claimed by issue.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   req          per-source write request
//   req_reg      per-source register index, source i at [i*REG_W +: REG_W]
//   req_data     per-source data, source i at [i*DATA_W +: DATA_W]
//   gnt          one-hot (or zero) combinational grant
//   wr_en        register-file write strobe
//   wr_sel       committed source index (register C mux select)
//   wr_reg       committed register index
//   wr_data      committed data
//   alloc_valid  issue stage claims alloc_reg as a destination
//   alloc_reg    destination being claimed
//   alloc_ok     claim accepted this cycle (combinational)
//   busy_vec     per-register outstanding-write flag
module reg_write_scheduler #(
  parameter int DATA_W = 8,
  parameter int REG_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [4*REG_W-1:0]    req_reg,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            gnt,
  output logic                  wr_en,
  output logic [1:0]            wr_sel,
  output logic [REG_W-1:0]      wr_reg,
  output logic [DATA_W-1:0]     wr_data,
  input  logic                  alloc_valid,
  input  logic [REG_W-1:0]      alloc_reg,
  output logic                  alloc_ok,
  output logic [2**REG_W-1:0]   busy_vec
);

  localparam int NREGS = 2**REG_W;

  logic [1:0]        r_rr_ptr;
  logic              r_wr_en;
  logic [1:0]        r_wr_sel;
  logic [REG_W-1:0]  r_wr_reg;
  logic [DATA_W-1:0] r_wr_data;
  logic [NREGS-1:0]  r_busy;

  logic [1:0]        w_idx;
  logic [1:0]        w_win;
  logic              w_found;
  logic              w_xfer;
  logic [REG_W-1:0]  w_win_reg;
  logic [DATA_W-1:0] w_win_data;
  logic              w_alloc_ok;
  logic [NREGS-1:0]  w_busy_nxt;

  // Round-robin search beginning one past the last accepted source.
  always_comb begin
    w_idx   = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_rr_ptr + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Nothing is granted while reset is high so in-flight requests are dropped.
  assign w_xfer     = w_found && !reset;
  assign gnt        = w_xfer ? (4'b0001 << w_win) : 4'b0000;
  assign w_win_reg  = req_reg[int'(w_win)*REG_W +: REG_W];
  assign w_win_data = req_data[int'(w_win)*DATA_W +: DATA_W];
  assign w_alloc_ok = alloc_valid && !r_busy[alloc_reg] && !reset;

  // Clear first, then set, so a same-cycle claim of the written register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_xfer)
      w_busy_nxt[w_win_reg] = 1'b0;
    if (w_alloc_ok)
      w_busy_nxt[alloc_reg] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr  <= 2'd3;
      r_wr_en   <= 1'b0;
      r_wr_sel  <= '0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
      r_busy    <= '0;
    end else begin
      r_wr_en <= w_xfer;
      r_busy  <= w_busy_nxt;
      if (w_xfer) begin
        r_rr_ptr  <= w_win;
        r_wr_sel  <= w_win;
        r_wr_reg  <= w_win_reg;
        r_wr_data <= w_win_data;
      end
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_sel   = r_wr_sel;
  assign wr_reg   = r_wr_reg;
  assign wr_data  = r_wr_data;
  assign alloc_ok = w_alloc_ok;
  assign busy_vec = r_busy;

endmodule
